// File: rtl/tc_pl_cap_sched.sv
// Capture scheduler for the PL capture path.
// Each trigger runs REPEAT passes over N gain steps, with a gain-set handshake and then a data-capture handshake per step.
module tc_pl_cap_sched #(
  parameter int CAP0_1 = 3,
  parameter int CAP0_9 = 32,
  parameter int REP_W  = 8,
  parameter int TMO_W  = 24
) (
  input  logic              clk125,
  input  logic              rst,
  input  logic              cap_trig,
  input  logic              cap_abort,
  input  logic [CAP0_1-1:0] gain_number,
  input  logic [REP_W-1:0]  repeat_num,
  input  logic [TMO_W-1:0]  step_timeout,
  output logic [CAP0_1-2:0] gain_value,
  output logic              gain_en,
  input  logic              gain_cmpt,
  output logic              data_en,
  input  logic              data_cmpt,
  output logic              cap_cing,
  output logic              cap_cmpt,
  output logic              cap_err,
  output logic [1:0]        cap_err_code,
  output logic [REP_W-1:0]  rep_idx,
  output logic [CAP0_9-1:0] cap_time
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GREQ  = 3'd1;
  localparam logic [2:0] S_GWAIT = 3'd2;
  localparam logic [2:0] S_DREQ  = 3'd3;
  localparam logic [2:0] S_DWAIT = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam logic [CAP0_1-1:0] N_ONE = {{(CAP0_1-1){1'b0}}, 1'b1};
  localparam logic [CAP0_1-1:0] N_MAX = {1'b1, {(CAP0_1-1){1'b0}}};
  localparam logic [REP_W-1:0]  R_ONE = {{(REP_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  W_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [CAP0_1-1:0] n_q, n_d;
  logic [REP_W-1:0]  r_q, r_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TMO_W-1:0]  wd_q, wd_d;
  logic [CAP0_1-2:0] gain_value_q, gain_value_d;
  logic [REP_W-1:0]  rep_idx_q, rep_idx_d;
  logic [CAP0_9-1:0] cap_time_q, cap_time_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              wd_expired;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    r_d          = r_q;
    tmo_d        = tmo_q;
    wd_d         = wd_q;
    gain_value_d = gain_value_q;
    rep_idx_d    = rep_idx_q;
    cap_time_d   = cap_time_q;
    err_code_d   = err_code_q;
    wd_expired   = (tmo_q != '0) && (wd_q == tmo_q);

    if (state_q != S_IDLE && cap_time_q != '1) cap_time_d = cap_time_q + 1'b1;

    // Abort overrides both completion and timeout; ERR is already on its way out.
    if (cap_abort && state_q != S_IDLE && state_q != S_ERR) begin
      state_d    = S_ERR;
      err_code_d = 2'd3;
    end else begin
      case (state_q)
        S_IDLE: if (cap_trig) begin
          if (gain_number == '0)        n_d = N_ONE;
          else if (gain_number > N_MAX) n_d = N_MAX;
          else                          n_d = gain_number;
          r_d          = (repeat_num == '0) ? R_ONE : repeat_num;
          tmo_d        = step_timeout;
          cap_time_d   = '0;
          err_code_d   = 2'd0;
          rep_idx_d    = '0;
          gain_value_d = '0;
          state_d      = S_GREQ;
        end
        S_GREQ: begin
          wd_d    = W_ONE;
          state_d = S_GWAIT;
        end
        S_GWAIT: begin
          if (gain_cmpt) state_d = S_DREQ;
          else if (wd_expired) begin
            state_d    = S_ERR;
            err_code_d = 2'd1;
          end else if (wd_q != '1) wd_d = wd_q + 1'b1;
        end
        S_DREQ: begin
          wd_d    = W_ONE;
          state_d = S_DWAIT;
        end
        S_DWAIT: begin
          if (data_cmpt) state_d = S_NEXT;
          else if (wd_expired) begin
            state_d    = S_ERR;
            err_code_d = 2'd2;
          end else if (wd_q != '1) wd_d = wd_q + 1'b1;
        end
        S_NEXT: begin
          if ({1'b0, gain_value_q} < n_q - N_ONE) begin
            gain_value_d = gain_value_q + 1'b1;
            state_d      = S_GREQ;
          end else if (rep_idx_q < r_q - R_ONE) begin
            gain_value_d = '0;
            rep_idx_d    = rep_idx_q + 1'b1;
            state_d      = S_GREQ;
          end else state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      r_q          <= '0;
      tmo_q        <= '0;
      wd_q         <= '0;
      gain_value_q <= '0;
      rep_idx_q    <= '0;
      cap_time_q   <= '0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      r_q          <= r_d;
      tmo_q        <= tmo_d;
      wd_q         <= wd_d;
      gain_value_q <= gain_value_d;
      rep_idx_q    <= rep_idx_d;
      cap_time_q   <= cap_time_d;
      err_code_q   <= err_code_d;
    end
  end

  assign gain_en      = (state_q == S_GREQ);
  assign data_en      = (state_q == S_DREQ);
  assign cap_cing     = (state_q != S_IDLE);
  assign cap_cmpt     = (state_q == S_DONE);
  assign cap_err      = (state_q == S_ERR);
  assign cap_err_code = err_code_q;
  assign gain_value   = gain_value_q;
  assign rep_idx      = rep_idx_q;
  assign cap_time     = cap_time_q;

endmodule

// File: tb/tb_tc_pl_cap_sched.sv
// Directed bench for tc_pl_cap_sched.
// It checks hand-computed outputs at fixed cycle offsets and counts pulses with a monitor.
module tb_tc_pl_cap_sched;

  logic        clk125;
  logic        rst;
  logic        cap_trig;
  logic        cap_abort;
  logic [2:0]  gain_number;
  logic [7:0]  repeat_num;
  logic [23:0] step_timeout;
  logic [1:0]  gain_value;
  logic        gain_en;
  logic        gain_cmpt;
  logic        data_en;
  logic        data_cmpt;
  logic        cap_cing;
  logic        cap_cmpt;
  logic        cap_err;
  logic [1:0]  cap_err_code;
  logic [7:0]  rep_idx;
  logic [31:0] cap_time;

  int total = 0;
  int bad   = 0;
  int gain_en_cnt = 0;
  int data_en_cnt = 0;
  int cmpt_cnt    = 0;
  int err_cnt     = 0;
  int snap_g, snap_d, snap_c, snap_e;

  tc_pl_cap_sched dut (
    .clk125(clk125), .rst(rst), .cap_trig(cap_trig), .cap_abort(cap_abort),
    .gain_number(gain_number), .repeat_num(repeat_num), .step_timeout(step_timeout),
    .gain_value(gain_value), .gain_en(gain_en), .gain_cmpt(gain_cmpt),
    .data_en(data_en), .data_cmpt(data_cmpt), .cap_cing(cap_cing),
    .cap_cmpt(cap_cmpt), .cap_err(cap_err), .cap_err_code(cap_err_code),
    .rep_idx(rep_idx), .cap_time(cap_time)
  );

  initial clk125 = 1'b0;
  always #4 clk125 = ~clk125;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk125) begin
    if (gain_en)  gain_en_cnt++;
    if (data_en)  data_en_cnt++;
    if (cap_cmpt) cmpt_cnt++;
    if (cap_err)  err_cnt++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] gn, input logic [7:0] rn, input logic [23:0] tmo);
    gain_number  = gn;
    repeat_num   = rn;
    step_timeout = tmo;
    cap_trig     = 1'b1;
    tick();
    cap_trig     = 1'b0;
  endtask

  // Entered in GREQ; returns in NEXT after both handshakes, each cmpt gd cycles after its en.
  task automatic doStep(input int gd, input int exp_gv, input int exp_rep);
    checkOutput($sformatf("gain_en_p%0d_g%0d", exp_rep, exp_gv), 64'(gain_en), 64'd1);
    checkOutput($sformatf("gain_value_p%0d_g%0d", exp_rep, exp_gv), 64'(gain_value), 64'(exp_gv));
    checkOutput($sformatf("rep_idx_p%0d_g%0d", exp_rep, exp_gv), 64'(rep_idx), 64'(exp_rep));
    repeat (gd) tick();
    gain_cmpt = 1'b1;
    tick();
    gain_cmpt = 1'b0;
    checkOutput($sformatf("data_en_p%0d_g%0d", exp_rep, exp_gv), 64'(data_en), 64'd1);
    repeat (gd) tick();
    data_cmpt = 1'b1;
    tick();
    data_cmpt = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cap_trig = 1'b0; cap_abort = 1'b0; gain_cmpt = 1'b0; data_cmpt = 1'b0;
    gain_number = 3'd1; repeat_num = 8'd1; step_timeout = 24'd0;
    tick();
    tick();
    checkOutput("reset_outputs",
      64'({gain_value, gain_en, data_en, cap_cing, cap_cmpt, cap_err, cap_err_code, rep_idx, cap_time}), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] T1 single step");
    applyStimulus(3'd1, 8'd1, 24'd0);
    checkOutput("t1_cap_time_greq", 64'(cap_time), 64'd0);
    doStep(3, 0, 0);
    checkOutput("t1_no_cmpt_in_next", 64'(cap_cmpt), 64'd0);
    tick();
    checkOutput("t1_cap_cmpt", 64'(cap_cmpt), 64'd1);
    checkOutput("t1_cing_in_done", 64'(cap_cing), 64'd1);
    tick();
    checkOutput("t1_cap_time_end", 64'(cap_time), 64'd10);
    checkOutput("t1_err_code", 64'(cap_err_code), 64'd0);
    checkOutput("t1_idle", 64'(cap_cing), 64'd0);

    $display("[TB] T2 four gains two passes");
    snap_g = gain_en_cnt; snap_c = cmpt_cnt;
    applyStimulus(3'd4, 8'd2, 24'd0);
    for (int p = 0; p < 2; p++) begin
      for (int g = 0; g < 4; g++) begin
        doStep(1, g, p);
        if (!(p == 1 && g == 3)) tick();
      end
    end
    tick();
    checkOutput("t2_cap_cmpt", 64'(cap_cmpt), 64'd1);
    tick();
    checkOutput("t2_gain_en_count", 64'(gain_en_cnt - snap_g), 64'd8);
    checkOutput("t2_cmpt_count", 64'(cmpt_cnt - snap_c), 64'd1);
    checkOutput("t2_gain_value_held", 64'(gain_value), 64'd3);

    $display("[TB] T3 data timeout");
    applyStimulus(3'd1, 8'd1, 24'd16);
    repeat (2) tick();
    gain_cmpt = 1'b1;
    tick();
    gain_cmpt = 1'b0;
    checkOutput("t3_data_en", 64'(data_en), 64'd1);
    repeat (16) tick();
    checkOutput("t3_no_err_at_16", 64'(cap_err), 64'd0);
    tick();
    checkOutput("t3_cap_err_at_17", 64'(cap_err), 64'd1);
    checkOutput("t3_err_code", 64'(cap_err_code), 64'd2);
    tick();
    checkOutput("t3_err_code_sticky", 64'(cap_err_code), 64'd2);
    checkOutput("t3_idle", 64'(cap_cing), 64'd0);
    applyStimulus(3'd1, 8'd1, 24'd0);
    checkOutput("t3_err_code_cleared", 64'(cap_err_code), 64'd0);
    doStep(1, 0, 0);
    tick();
    tick();

    $display("[TB] T4 cmpt on expiry cycle");
    snap_e = err_cnt;
    applyStimulus(3'd1, 8'd1, 24'd16);
    repeat (16) tick();
    gain_cmpt = 1'b1;
    tick();
    gain_cmpt = 1'b0;
    checkOutput("t4_data_en", 64'(data_en), 64'd1);
    tick();
    data_cmpt = 1'b1;
    tick();
    data_cmpt = 1'b0;
    tick();
    checkOutput("t4_cap_cmpt", 64'(cap_cmpt), 64'd1);
    tick();
    checkOutput("t4_no_err", 64'(err_cnt - snap_e), 64'd0);

    $display("[TB] T5 abort beats cmpt");
    applyStimulus(3'd2, 8'd1, 24'd0);
    tick();
    snap_g = gain_en_cnt; snap_d = data_en_cnt;
    cap_trig = 1'b1;
    tick();
    cap_trig = 1'b0;
    checkOutput("t5_trig_ignored_cing", 64'(cap_cing), 64'd1);
    gain_cmpt = 1'b1; cap_abort = 1'b1;
    tick();
    gain_cmpt = 1'b0; cap_abort = 1'b0;
    checkOutput("t5_cap_err", 64'(cap_err), 64'd1);
    checkOutput("t5_err_code", 64'(cap_err_code), 64'd3);
    tick();
    tick();
    checkOutput("t5_no_data_en", 64'(data_en_cnt - snap_d), 64'd0);
    checkOutput("t5_no_restart", 64'(gain_en_cnt - snap_g), 64'd0);
    checkOutput("t5_idle", 64'(cap_cing), 64'd0);

    $display("[TB] T6 clamps and reset mid-run");
    snap_g = gain_en_cnt;
    applyStimulus(3'd0, 8'd0, 24'd0);
    doStep(1, 0, 0);
    tick();
    checkOutput("t6_zero_cfg_cmpt", 64'(cap_cmpt), 64'd1);
    tick();
    checkOutput("t6_zero_cfg_steps", 64'(gain_en_cnt - snap_g), 64'd1);
    snap_g = gain_en_cnt;
    applyStimulus(3'd7, 8'd1, 24'd0);
    for (int g = 0; g < 4; g++) begin
      doStep(1, g, 0);
      if (g < 3) tick();
    end
    tick();
    checkOutput("t6_clamp_cmpt", 64'(cap_cmpt), 64'd1);
    tick();
    checkOutput("t6_clamp_steps", 64'(gain_en_cnt - snap_g), 64'd4);
    applyStimulus(3'd4, 8'd1, 24'd0);
    doStep(1, 0, 0);
    tick();
    doStep(1, 1, 0);
    tick();
    tick();
    gain_cmpt = 1'b1;
    tick();
    gain_cmpt = 1'b0;
    tick();
    snap_c = cmpt_cnt; snap_e = err_cnt;
    checkOutput("t6_in_dwait_gv", 64'(gain_value), 64'd2);
    rst = 1'b1;
    tick();
    checkOutput("t6_reset_outputs",
      64'({gain_value, gain_en, data_en, cap_cing, cap_cmpt, cap_err, cap_err_code, rep_idx, cap_time}), 64'd0);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("t6_no_pulses_after_reset", 64'((cmpt_cnt - snap_c) + (err_cnt - snap_e)), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
